fxp_acc_array: RTL and testbench
================================

Name: fxp_acc_array

Overview:
- Multi-channel saturating fixed-point accumulator; successor to the single combinational add/sub saturator.
- Holds C_CHANNELS signed accumulators. Accepts a stream of {channel, op, operand} over valid/ready and returns each updated accumulator value over valid/ready.
- Two-stage pipeline; sits between the kinematics datapath and the AXI register block, e.g. per-leg joint-angle integration.

Parameters:
- C_FXP_LENGTH, 16, total word width in bits (>=4).
- C_FXP_POINT, 12, fractional bits (< C_FXP_LENGTH).
- C_CHANNELS, 6, number of accumulators (>=2).
- C_CH_WIDTH, $clog2(C_CHANNELS), channel index width; localparam, not overridable.

Ports:
- S_AXI_ACLK  in  1  clock, all logic on the rising edge.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- S_CLEAR_ALL  in  1  synchronous zeroing of all accumulators and sticky flags.
- S_IN_VALID  in  1  input command valid.
- S_IN_READY  out  1  input command ready.
- S_IN_CH  in  C_CH_WIDTH  target channel.
- S_IN_OP  in  2  op code: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
- S_IN_DATA  in  C_FXP_LENGTH  signed operand.
- S_OUT_VALID  out  1  result valid.
- S_OUT_READY  in  1  result ready.
- S_OUT_CH  out  C_CH_WIDTH  channel of the result.
- S_OUT_DATA  out  C_FXP_LENGTH  new accumulator value.
- S_OUT_OF  out  1  this op saturated.
- S_OUT_ERR  out  1  channel index out of range.
- S_OF_STICKY  out  C_CHANNELS  per-channel sticky saturation flags.

Behaviour:
- Reset (async assert, sync release): stage A/B valid=0; all accumulators=0; S_OF_STICKY=0; S_OUT_DATA=0; S_OUT_CH=0; S_OUT_OF=0; S_OUT_ERR=0; S_OUT_VALID=0.
  - S_IN_READY=1 combinationally while reset is deasserted, both stages empty.
  - Reset mid-operation discards all in-flight commands.
- Handshakes:
  - Transfer occurs when valid&ready. Valid must not depend on ready.
  - Outputs hold stable while S_OUT_VALID & !S_OUT_READY.
- Pipeline:
  - Stage A registers the accepted command.
  - Stage B is the output register.
  - advB = !B_valid | S_OUT_READY.
  - S_IN_READY = !A_valid | advB.
  - Full throughput of one command per cycle.
  - Latency: command accepted at edge N -> S_OUT_VALID at edge N+2 (no backpressure).
- Compute, combinational in stage A, on acc[ch]:
  - ADD: acc+D.
  - SUB: acc-D.
  - LOAD: D.
  - CLEAR: 0.
  - ADD/SUB use a C_FXP_LENGTH+1-bit sum. If the top two bits differ, saturate:
    - 01 -> MAX_POS = 2^(L-1)-1.
    - 10 -> MAX_NEG = -2^(L-1).
  - LOAD and CLEAR never saturate.
- Commit:
  - On the edge where A advances into B, acc[ch] gets the result and B captures {ch, result, of, err}.
  - If of=1, S_OF_STICKY[ch] is set.
  - LOAD and CLEAR also clear S_OF_STICKY[ch].
  - Back-to-back commands to the same channel see the committed value; no hazard, no forwarding.
- Out-of-range (ch >= C_CHANNELS):
  - Command consumed; no accumulator or sticky change.
  - Output has DATA=0, OF=0, ERR=1.
- S_CLEAR_ALL:
  - Zeroes every accumulator and sticky flag at the edge. It takes priority over a same-edge commit, whose write is suppressed.
  - The in-flight result is still delivered with its computed value.
  - Does not affect pipeline valids.
- Simultaneous advance A->B and new input acceptance in one cycle is permitted.

Decomposition:
- Shared package fxp_pkg:
  - Op-code constants OP_ADD/OP_SUB/OP_LOAD/OP_CLEAR.
  - MAX_POS/MAX_NEG generator functions parametrised by length.
- Sub-module fxp_sat_addsub:
  - Combinational, parametrised C_FXP_LENGTH.
  - Inputs A, B, SUB. Outputs saturated result and OF.
  - Instantiated once in stage A.

Test Plan:
- Q4.12, L=16. LOAD ch2 0x1000, then ADD ch2 0x0800 -> outputs 0x1000 then 0x1800, OF=0. First result at +2 cycles, second at +3.
- LOAD ch0 0x7000, ADD ch0 0x2000 -> 0x7FFF, OF=1, STICKY[0]=1.
- CLEAR ch0, then SUB ch0 0x8000 -> 0x0000, then 0x7FFF with OF=1. CLEAR drops STICKY[0], SUB sets it again.
- Hold S_OUT_READY=0 with 4 queued commands:
  - S_IN_READY falls after 2 accepts.
  - Outputs stay stable.
  - Release -> all 4 results in order with no loss or duplication.
- S_IN_CH=7 with C_CHANNELS=6 -> ERR=1, DATA=0, accumulators unchanged. Also S_CLEAR_ALL on the commit edge of ADD ch1 0x0100: output 0x0100, acc[1] reads 0 afterwards.
- Assert S_AXI_ARESETN=0 with both stages full -> S_OUT_VALID=0 immediately; after release, all acc=0 and STICKY=0.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point accumulator array: op codes and
// saturation limit generators.
package fxp_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD   = 2'b00;
  localparam op_t OP_SUB   = 2'b01;
  localparam op_t OP_LOAD  = 2'b10;
  localparam op_t OP_CLEAR = 2'b11;

  // Callers truncate the 64-bit pattern to their word length.
  function automatic logic [63:0] fxp_max_pos(input int unsigned len);
    return (64'd1 << (len - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] fxp_max_neg(input int unsigned len);
    return 64'd1 << (len - 1);
  endfunction

endpackage

// File: rtl/fxp_acc_array_if.sv
// Command and result streams of the accumulator array, each a valid/ready pair.
interface fxp_acc_array_if #(
  parameter int unsigned C_FXP_LENGTH = 16,
  parameter int unsigned C_CHANNELS   = 6
);
  localparam int unsigned C_CH_WIDTH = $clog2(C_CHANNELS);

  logic                    S_IN_VALID;
  logic                    S_IN_READY;
  logic [C_CH_WIDTH-1:0]   S_IN_CH;
  logic [1:0]              S_IN_OP;
  logic [C_FXP_LENGTH-1:0] S_IN_DATA;

  logic                    S_OUT_VALID;
  logic                    S_OUT_READY;
  logic [C_CH_WIDTH-1:0]   S_OUT_CH;
  logic [C_FXP_LENGTH-1:0] S_OUT_DATA;
  logic                    S_OUT_OF;
  logic                    S_OUT_ERR;

  modport master (
    output S_IN_VALID, S_IN_CH, S_IN_OP, S_IN_DATA, S_OUT_READY,
    input  S_IN_READY, S_OUT_VALID, S_OUT_CH, S_OUT_DATA, S_OUT_OF, S_OUT_ERR
  );

  modport slave (
    input  S_IN_VALID, S_IN_CH, S_IN_OP, S_IN_DATA, S_OUT_READY,
    output S_IN_READY, S_OUT_VALID, S_OUT_CH, S_OUT_DATA, S_OUT_OF, S_OUT_ERR
  );

endinterface

// File: rtl/fxp_sat_addsub.sv
// Combinational signed add/subtract with saturation to the word range.
module fxp_sat_addsub import fxp_pkg::*; #(
  parameter int unsigned C_FXP_LENGTH = 16
) (
  input  logic [C_FXP_LENGTH-1:0] a_i,
  input  logic [C_FXP_LENGTH-1:0] b_i,
  input  logic                    sub_i,
  output logic [C_FXP_LENGTH-1:0] res_o,
  output logic                    of_o
);

  localparam logic [C_FXP_LENGTH-1:0] MaxPos = C_FXP_LENGTH'(fxp_max_pos(C_FXP_LENGTH));
  localparam logic [C_FXP_LENGTH-1:0] MaxNeg = C_FXP_LENGTH'(fxp_max_neg(C_FXP_LENGTH));

  logic [C_FXP_LENGTH:0] a_ext;
  logic [C_FXP_LENGTH:0] b_ext;
  logic [C_FXP_LENGTH:0] sum;

  always_comb begin
    a_ext = {a_i[C_FXP_LENGTH-1], a_i};
    b_ext = {b_i[C_FXP_LENGTH-1], b_i};
    sum   = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);
    res_o = sum[C_FXP_LENGTH-1:0];
    of_o  = 1'b0;
    // Disagreeing top two bits mean the true result left the L-bit range.
    unique case (sum[C_FXP_LENGTH:C_FXP_LENGTH-1])
      2'b01: begin
        res_o = MaxPos;
        of_o  = 1'b1;
      end
      2'b10: begin
        res_o = MaxNeg;
        of_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fxp_acc_array.sv
// Multi-channel saturating fixed-point accumulator with a two-stage
// valid/ready pipeline: stage A holds the command, stage B the result.
module fxp_acc_array import fxp_pkg::*; #(
  parameter int unsigned C_FXP_LENGTH = 16,
  parameter int unsigned C_FXP_POINT  = 12,
  parameter int unsigned C_CHANNELS   = 6
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  S_CLEAR_ALL,
  fxp_acc_array_if.slave        acc_if,
  output logic [C_CHANNELS-1:0] S_OF_STICKY
);

  localparam int unsigned C_CH_WIDTH = $clog2(C_CHANNELS);

  if (C_FXP_POINT >= C_FXP_LENGTH || C_FXP_LENGTH < 4 || C_CHANNELS < 2) begin : gen_param_check
    $error("fxp_acc_array: invalid parameter combination");
  end

  logic                    a_valid_q;
  logic [C_CH_WIDTH-1:0]   a_ch_q;
  op_t                     a_op_q;
  logic [C_FXP_LENGTH-1:0] a_data_q;

  logic                    b_valid_q;
  logic [C_CH_WIDTH-1:0]   b_ch_q;
  logic [C_FXP_LENGTH-1:0] b_data_q;
  logic                    b_of_q;
  logic                    b_err_q;

  logic [C_FXP_LENGTH-1:0] acc_q [C_CHANNELS];
  logic [C_CHANNELS-1:0]   sticky_q;

  logic                    adv_b;
  logic                    in_ready;
  logic                    a_adv;
  logic                    ch_ok;
  logic [C_FXP_LENGTH-1:0] acc_rd;
  logic [C_FXP_LENGTH-1:0] sat_res;
  logic                    sat_of;
  logic [C_FXP_LENGTH-1:0] res_d;
  logic                    of_d;

  always_comb begin
    adv_b    = !b_valid_q | acc_if.S_OUT_READY;
    in_ready = !a_valid_q | adv_b;
    a_adv    = a_valid_q & adv_b;
    ch_ok    = 32'(a_ch_q) < C_CHANNELS;
    acc_rd   = '0;
    for (int i = 0; i < int'(C_CHANNELS); i++) begin
      if (a_ch_q == C_CH_WIDTH'(i)) acc_rd = acc_q[i];
    end
  end

  fxp_sat_addsub #(
    .C_FXP_LENGTH(C_FXP_LENGTH)
  ) u_sat_addsub (
    .a_i  (acc_rd),
    .b_i  (a_data_q),
    .sub_i(a_op_q == OP_SUB),
    .res_o(sat_res),
    .of_o (sat_of)
  );

  // Out-of-range channels yield a zero, non-saturated result.
  always_comb begin
    res_d = '0;
    of_d  = 1'b0;
    if (ch_ok) begin
      unique case (a_op_q)
        OP_ADD, OP_SUB: begin
          res_d = sat_res;
          of_d  = sat_of;
        end
        OP_LOAD:  res_d = a_data_q;
        OP_CLEAR: res_d = '0;
        default:  res_d = '0;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      a_valid_q <= 1'b0;
      a_ch_q    <= '0;
      a_op_q    <= OP_ADD;
      a_data_q  <= '0;
      b_valid_q <= 1'b0;
      b_ch_q    <= '0;
      b_data_q  <= '0;
      b_of_q    <= 1'b0;
      b_err_q   <= 1'b0;
    end else begin
      if (in_ready) begin
        a_valid_q <= acc_if.S_IN_VALID;
        if (acc_if.S_IN_VALID) begin
          a_ch_q   <= acc_if.S_IN_CH;
          a_op_q   <= acc_if.S_IN_OP;
          a_data_q <= acc_if.S_IN_DATA;
        end
      end
      if (adv_b) begin
        b_valid_q <= a_valid_q;
        if (a_valid_q) begin
          b_ch_q   <= a_ch_q;
          b_data_q <= res_d;
          b_of_q   <= of_d;
          b_err_q  <= !ch_ok;
        end
      end
    end
  end

  // Clear-all wins over the commit landing on the same edge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < int'(C_CHANNELS); i++) acc_q[i] <= '0;
      sticky_q <= '0;
    end else if (S_CLEAR_ALL) begin
      for (int i = 0; i < int'(C_CHANNELS); i++) acc_q[i] <= '0;
      sticky_q <= '0;
    end else if (a_adv && ch_ok) begin
      for (int i = 0; i < int'(C_CHANNELS); i++) begin
        if (a_ch_q == C_CH_WIDTH'(i)) begin
          acc_q[i] <= res_d;
          if (a_op_q == OP_LOAD || a_op_q == OP_CLEAR) begin
            sticky_q[i] <= 1'b0;
          end else if (of_d) begin
            sticky_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign acc_if.S_IN_READY  = in_ready;
  assign acc_if.S_OUT_VALID = b_valid_q;
  assign acc_if.S_OUT_CH    = b_ch_q;
  assign acc_if.S_OUT_DATA  = b_data_q;
  assign acc_if.S_OUT_OF    = b_of_q;
  assign acc_if.S_OUT_ERR   = b_err_q;
  assign S_OF_STICKY        = sticky_q;

endmodule

// File: tb/tb_fxp_acc_array.sv
// Bench for fxp_acc_array: directed scenarios plus random traffic checked
// against an integer reference model and an in-order result queue.
module tb_fxp_acc_array;

  localparam int unsigned L   = 16;
  localparam int unsigned NCH = 6;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] LDV = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] data;
    logic        of;
    logic        err;
    int          cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clear_all = 1'b0;
  logic [NCH-1:0] sticky;

  exp_t           exp_q[$];
  int             lat_q[$];
  int             m_acc [NCH];
  logic [NCH-1:0] m_sticky;
  int             n_vec = 0;
  int             n_err = 0;
  int             cyc = 0;
  int             pop_cnt = 0;
  logic [15:0]    last_data;
  logic           last_of;
  logic           last_err;

  logic [2:0]     bp_ch [4] = '{3'd3, 3'd3, 3'd4, 3'd5};
  logic [1:0]     bp_op [4] = '{ADD, ADD, SUB, LDV};
  logic [15:0]    bp_d  [4] = '{16'h0010, 16'h0020, 16'h0005, 16'h1234};

  always #5 clk = ~clk;

  fxp_acc_array_if #(.C_FXP_LENGTH(L), .C_CHANNELS(NCH)) acc_if ();

  fxp_acc_array #(
    .C_FXP_LENGTH(L),
    .C_FXP_POINT (12),
    .C_CHANNELS  (NCH)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .S_CLEAR_ALL  (clear_all),
    .acc_if       (acc_if),
    .S_OF_STICKY  (sticky)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NCH); i++) m_acc[i] = 0;
    m_sticky = '0;
  endtask

  // Accumulator semantics in plain integer arithmetic, applied in acceptance order.
  task automatic model_cmd(input logic [2:0] ch, input logic [1:0] op, input logic [15:0] d);
    exp_t e;
    int   r;
    int   dv;
    e.ch   = ch;
    e.cyc  = cyc;
    e.of   = 1'b0;
    e.err  = 1'b0;
    e.data = '0;
    if (32'(ch) >= NCH) begin
      e.err = 1'b1;
    end else begin
      dv = int'($signed(d));
      case (op)
        ADD:     r = m_acc[ch] + dv;
        SUB:     r = m_acc[ch] - dv;
        LDV:     r = dv;
        default: r = 0;
      endcase
      if (op == ADD || op == SUB) begin
        if (r > 32767) begin
          r = 32767;
          e.of = 1'b1;
        end else if (r < -32768) begin
          r = -32768;
          e.of = 1'b1;
        end
      end
      m_acc[ch] = r;
      if (op == LDV || op == CLR) m_sticky[ch] = 1'b0;
      else if (e.of) m_sticky[ch] = 1'b1;
      e.data = r[15:0];
    end
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive at the falling edge, sample 2 ns later, release after the rising edge.
  task automatic step(input logic v, input logic [2:0] ch, input logic [1:0] op,
                      input logic [15:0] d, input logic ordy, input logic clr,
                      output logic fired);
    exp_t e;
    @(negedge clk);
    acc_if.S_IN_VALID  = v;
    acc_if.S_IN_CH     = ch;
    acc_if.S_IN_OP     = op;
    acc_if.S_IN_DATA   = d;
    acc_if.S_OUT_READY = ordy;
    clear_all          = clr;
    #2;
    fired = v & acc_if.S_IN_READY;
    if (acc_if.S_OUT_VALID && ordy) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out_valid", 32'(acc_if.S_OUT_VALID), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_ch",   32'(acc_if.S_OUT_CH),   32'(e.ch));
        check_eq("out_data", 32'(acc_if.S_OUT_DATA), 32'(e.data));
        check_eq("out_of",   32'(acc_if.S_OUT_OF),   32'(e.of));
        check_eq("out_err",  32'(acc_if.S_OUT_ERR),  32'(e.err));
        last_data = acc_if.S_OUT_DATA;
        last_of   = acc_if.S_OUT_OF;
        last_err  = acc_if.S_OUT_ERR;
        lat_q.push_back(cyc - e.cyc);
        pop_cnt++;
      end
    end
    if (clr) model_reset();
    if (fired) model_cmd(ch, op, d);
    @(posedge clk);
    cyc++;
    #1;
    acc_if.S_IN_VALID  = 1'b0;
    acc_if.S_OUT_READY = 1'b0;
    clear_all          = 1'b0;
  endtask

  task automatic send(input logic [2:0] ch, input logic [1:0] op, input logic [15:0] d);
    logic f;
    f = 1'b0;
    for (int i = 0; i < 20 && !f; i++) step(1'b1, ch, op, d, 1'b1, 1'b0, f);
    if (!f) check_eq("send_timeout", 32'(f), 32'd1);
  endtask

  task automatic drain();
    logic f;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, 3'd0, ADD, 16'h0, 1'b1, 1'b0, f);
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_cmd(input logic [2:0] ch, input logic [1:0] op, input logic [15:0] d);
    send(ch, op, d);
    drain();
  endtask

  initial begin
    logic        f;
    int          idx;
    int          j;
    int          pops0;
    logic [15:0] hold_data;
    logic [2:0]  hold_ch;
    logic [15:0] rd;

    acc_if.S_IN_VALID  = 1'b0;
    acc_if.S_IN_CH     = '0;
    acc_if.S_IN_OP     = '0;
    acc_if.S_IN_DATA   = '0;
    acc_if.S_OUT_READY = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(acc_if.S_OUT_VALID), 32'd0);
    check_eq("rst_out_data",  32'(acc_if.S_OUT_DATA),  32'd0);
    check_eq("rst_out_ch",    32'(acc_if.S_OUT_CH),    32'd0);
    check_eq("rst_out_of",    32'(acc_if.S_OUT_OF),    32'd0);
    check_eq("rst_out_err",   32'(acc_if.S_OUT_ERR),   32'd0);
    check_eq("rst_sticky",    32'(sticky),             32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(acc_if.S_IN_READY), 32'd1);

    // Back-to-back LOAD/ADD on channel 2 with latency check.
    lat_q.delete();
    step(1'b1, 3'd2, LDV, 16'h1000, 1'b1, 1'b0, f);
    check_eq("t1_accept0", 32'(f), 32'd1);
    step(1'b1, 3'd2, ADD, 16'h0800, 1'b1, 1'b0, f);
    check_eq("t1_accept1", 32'(f), 32'd1);
    drain();
    check_eq("t1_nres", 32'(lat_q.size()), 32'd2);
    if (lat_q.size() == 2) begin
      check_eq("t1_lat0", 32'(lat_q[0]), 32'd2);
      check_eq("t1_lat1", 32'(lat_q[1] + 1), 32'd3);
    end
    check_eq("t1_data", 32'(last_data), 32'h1800);

    // Positive saturation and sticky set.
    run_cmd(3'd0, LDV, 16'h7000);
    run_cmd(3'd0, ADD, 16'h2000);
    check_eq("t2_data", 32'(last_data), 32'h7FFF);
    check_eq("t2_of", 32'(last_of), 32'd1);
    check_eq("t2_sticky0", 32'(sticky[0]), 32'd1);

    // CLEAR drops sticky, subtracting MAX_NEG saturates again.
    run_cmd(3'd0, CLR, 16'h1234);
    check_eq("t3_clr_data", 32'(last_data), 32'h0000);
    check_eq("t3_clr_sticky0", 32'(sticky[0]), 32'd0);
    run_cmd(3'd0, SUB, 16'h8000);
    check_eq("t3_sub_data", 32'(last_data), 32'h7FFF);
    check_eq("t3_sub_of", 32'(last_of), 32'd1);
    check_eq("t3_sub_sticky0", 32'(sticky[0]), 32'd1);

    // Backpressure: four queued commands, output stalled.
    idx = 0;
    hold_data = '0;
    hold_ch = '0;
    pops0 = pop_cnt;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, bp_ch[idx], bp_op[idx], bp_d[idx], 1'b0, 1'b0, f);
      if (f) idx++;
      if (k == 1) begin
        hold_data = acc_if.S_OUT_DATA;
        hold_ch   = acc_if.S_OUT_CH;
      end
    end
    check_eq("bp_accepts", 32'(idx), 32'd2);
    check_eq("bp_in_ready", 32'(acc_if.S_IN_READY), 32'd0);
    check_eq("bp_out_valid", 32'(acc_if.S_OUT_VALID), 32'd1);
    check_eq("bp_hold_data", 32'(acc_if.S_OUT_DATA), 32'(hold_data));
    check_eq("bp_hold_ch", 32'(acc_if.S_OUT_CH), 32'(hold_ch));
    for (int k = 0; k < 20 && !(idx == 4 && exp_q.size() == 0); k++) begin
      j = (idx < 4) ? idx : 0;
      step(idx < 4, bp_ch[j], bp_op[j], bp_d[j], 1'b1, 1'b0, f);
      if (f) idx++;
    end
    check_eq("bp_all_accepted", 32'(idx), 32'd4);
    check_eq("bp_result_count", 32'(pop_cnt - pops0), 32'd4);

    // Out-of-range channel leaves state alone.
    run_cmd(3'd7, LDV, 16'h5555);
    check_eq("oor_err", 32'(last_err), 32'd1);
    check_eq("oor_data", 32'(last_data), 32'd0);
    run_cmd(3'd2, ADD, 16'h0000);
    check_eq("oor_ch2_kept", 32'(last_data), 32'h1800);

    // Clear-all on the commit edge of ADD ch1.
    run_cmd(3'd1, LDV, 16'h0000);
    step(1'b1, 3'd1, ADD, 16'h0100, 1'b1, 1'b0, f);
    check_eq("ca_accept", 32'(f), 32'd1);
    step(1'b0, 3'd0, ADD, 16'h0000, 1'b1, 1'b1, f);
    drain();
    check_eq("ca_inflight_data", 32'(last_data), 32'h0100);
    check_eq("ca_sticky", 32'(sticky), 32'd0);
    run_cmd(3'd1, ADD, 16'h0000);
    check_eq("ca_ch1_zero", 32'(last_data), 32'd0);

    // Random traffic with random backpressure.
    for (int k = 0; k < 600; k++) begin
      rd = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rd = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), rd,
           $urandom_range(0, 9) < 7, 1'b0, f);
    end
    drain();
    check_eq("rand_sticky", 32'(sticky), 32'(m_sticky));

    // Reset with both stages full.
    step(1'b1, 3'd3, ADD, 16'h0001, 1'b0, 1'b0, f);
    step(1'b1, 3'd4, ADD, 16'h0001, 1'b0, 1'b0, f);
    step(1'b1, 3'd5, ADD, 16'h0001, 1'b0, 1'b0, f);
    check_eq("prerst_out_valid", 32'(acc_if.S_OUT_VALID), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(acc_if.S_OUT_VALID), 32'd0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < int'(NCH); c++) begin
      run_cmd(3'(c), ADD, 16'h0000);
      check_eq("postrst_acc", 32'(last_data), 32'd0);
    end
    check_eq("postrst_sticky", 32'(sticky), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
